// File: rtl/store_monitor.sv
// Hardware pass/fail monitor on the data-memory write bus: classifies stores,
// latches a terminal verdict, runs a watchdog, counts stores and drives an LED.
module store_monitor #(
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter int          TIMEOUT     = 1000,
  parameter int          BLINK_DIV   = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [1:0]  status,
  output logic        done,
  output logic [31:0] fail_adr,
  output logic [31:0] fail_data,
  output logic [15:0] store_count,
  output logic        led
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] fail_adr_q, fail_adr_d;
  logic [31:0] fail_data_q, fail_data_d;
  logic [15:0] count_q, count_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] div_q, div_d;
  logic        led_q, led_d;

  // Next-state: store classification, watchdog, counters and LED divider.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    count_d     = count_q;
    wd_d        = wd_q;
    div_d       = div_q;
    led_d       = led_q;
    case (state_q)
      ST_RUN: begin
        wd_d = wd_q + 32'd1;
        if (MemWrite) begin
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end else begin
            count_d = count_q;
          end
          if ((DataAdr == PASS_ADR) && (WriteData == PASS_DATA)) begin
            state_d = ST_PASS;
            div_d   = 32'd0;
            led_d   = 1'b0;
          end else if (DataAdr == SCRATCH_ADR) begin
            // Scratch stores never terminate, so the watchdog still applies.
            if (wd_q == WD_LAST) begin
              state_d = ST_TIMEOUT;
              led_d   = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d     = ST_FAIL;
            fail_adr_d  = DataAdr;
            fail_data_d = WriteData;
            led_d       = 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = ST_TIMEOUT;
          led_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PASS: begin
        if (div_q == BLINK_LAST) begin
          div_d = 32'd0;
          led_d = ~led_q;
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      ST_FAIL, ST_TIMEOUT: begin
        led_d = 1'b1;
      end
      default: begin
        state_d = ST_FAIL;
        led_d   = 1'b1;
      end
    endcase
    done_d = (state_d != ST_RUN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      done_q      <= 1'b0;
      fail_adr_q  <= 32'd0;
      fail_data_q <= 32'd0;
      count_q     <= 16'd0;
      wd_q        <= 32'd0;
      div_q       <= 32'd0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      div_q       <= div_d;
      led_q       <= led_d;
    end
  end

  assign status      = state_q;
  assign done        = done_q;
  assign fail_adr    = fail_adr_q;
  assign fail_data   = fail_data_q;
  assign store_count = count_q;
  assign led         = led_q;

endmodule
